// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory-bus controller.
// Optional parity build: define CORE_MEM_PARITY_EN.
package core_mem_pkg;

  localparam int CORE_DATA_WIDTH = 36;
  localparam int CORE_ADDR_WIDTH = 14;

`ifdef CORE_MEM_PARITY_EN
  localparam int CORE_PARITY_BITS = 1;
`else
  localparam int CORE_PARITY_BITS = 0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR      = 3'd4
  } state_e;

  // Odd parity: the returned bit makes the total count of ones (data + bit) odd.
  function automatic logic odd_parity(input logic [CORE_DATA_WIDTH-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/core_mem_parity.sv
// Combinational odd-parity generator for write data and checker for RAM read words.
// Only instantiated when CORE_MEM_PARITY_EN is defined.
module core_mem_parity
  import core_mem_pkg::*;
#(
  parameter int DATA_WIDTH = CORE_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_par_o,
  input  logic [DATA_WIDTH:0]   rd_word_i,
  output logic                  rd_err_o
);

  generate
    if (DATA_WIDTH == CORE_DATA_WIDTH) begin : g_pkg_width
      assign wr_par_o = odd_parity(wr_data_i);
    end else begin : g_any_width
      assign wr_par_o = ~^wr_data_i;
    end
  endgenerate

  // A stored word with an even number of ones has lost (or gained) a bit.
  assign rd_err_o = ~^rd_word_i;

endmodule

// File: rtl/core_mem_ctl.sv
// Memory-bus controller between processor memory cycles and a single-port RAM.
// Define CORE_MEM_PARITY_EN to add an odd-parity bit per word and the par_err output.
module core_mem_ctl
  import core_mem_pkg::*;
#(
  parameter  int DATA_WIDTH = CORE_DATA_WIDTH,
  parameter  int ADDR_WIDTH = CORE_ADDR_WIDTH,
  localparam int RAM_WIDTH  = DATA_WIDTH + CORE_PARITY_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rq_cyc,
  input  logic                  rd_rq,
  input  logic                  wr_rq,
  input  logic [ADDR_WIDTH-1:0] ma,
  input  logic                  wr_rs,
  input  logic [DATA_WIDTH-1:0] mb_in,
  output logic                  addr_ack,
  output logic                  rd_rs,
  output logic [DATA_WIDTH-1:0] mb_out,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_data,
  output logic                  ram_we,
  input  logic [RAM_WIDTH-1:0]  ram_q
`ifdef CORE_MEM_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic                  wr_flag_q,  wr_flag_d;
  logic                  addr_ack_q, addr_ack_d;
  logic                  rd_rs_q,    rd_rs_d;
  logic [DATA_WIDTH-1:0] mb_out_q,   mb_out_d;
  logic [RAM_WIDTH-1:0]  ram_data_q, ram_data_d;
  logic                  ram_we_q,   ram_we_d;
  logic [RAM_WIDTH-1:0]  wr_word;

`ifdef CORE_MEM_PARITY_EN
  logic wr_par;
  logic rd_par_err;
  logic par_err_q, par_err_d;

  core_mem_parity #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .wr_data_i (mb_in),
    .wr_par_o  (wr_par),
    .rd_word_i (ram_q),
    .rd_err_o  (rd_par_err)
  );

  assign wr_word = {wr_par, mb_in};
`else
  assign wr_word = mb_in;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_flag_d  = wr_flag_q;
    mb_out_d   = mb_out_q;
    ram_data_d = ram_data_q;
    addr_ack_d = 1'b0;
    rd_rs_d    = 1'b0;
    ram_we_d   = 1'b0;
`ifdef CORE_MEM_PARITY_EN
    par_err_d  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (rq_cyc && (rd_rq || wr_rq)) begin
          addr_d     = ma;
          wr_flag_d  = wr_rq;
          addr_ack_d = 1'b1;
          state_d    = rd_rq ? ST_RD_WAIT : ST_WR_WAIT;
        end
      end

      // The RAM registers ram_addr at the end of this cycle.
      ST_RD_WAIT: state_d = ST_RD_DATA;

      ST_RD_DATA: begin
        mb_out_d = ram_q[DATA_WIDTH-1:0];
        rd_rs_d  = 1'b1;
`ifdef CORE_MEM_PARITY_EN
        par_err_d = rd_par_err;
`endif
        state_d  = wr_flag_q ? ST_WR_WAIT : ST_IDLE;
      end

      // wr_rs wins over a dropped rq_cyc in the same cycle; no timeout.
      ST_WR_WAIT: begin
        if (wr_rs) begin
          ram_data_d = wr_word;
          ram_we_d   = 1'b1;
          state_d    = ST_WR;
        end else if (!rq_cyc) begin
          state_d = ST_IDLE;
        end
      end

      ST_WR:   state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_flag_q  <= 1'b0;
      addr_ack_q <= 1'b0;
      rd_rs_q    <= 1'b0;
      mb_out_q   <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
`ifdef CORE_MEM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_flag_q  <= wr_flag_d;
      addr_ack_q <= addr_ack_d;
      rd_rs_q    <= rd_rs_d;
      mb_out_q   <= mb_out_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
`ifdef CORE_MEM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign addr_ack = addr_ack_q;
  assign rd_rs    = rd_rs_q;
  assign mb_out   = mb_out_q;
  assign busy     = (state_q != ST_IDLE);
  assign ram_addr = addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
`ifdef CORE_MEM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule
